// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the PC sequencer.
package pc_seq_pkg;

    localparam int unsigned ADDR_W       = 32;
    localparam int unsigned JUMP_INDEX_W = 26;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        HALT  = 2'd3
    } state_t;

endpackage

// File: rtl/pc_target_calc.sv
// Combinational next-address arithmetic: sequential, branch and jump targets.
module pc_target_calc
    import pc_seq_pkg::*;
#(
    parameter int unsigned WIDTH = ADDR_W
) (
    input  logic [WIDTH-1:0]        pc,
    input  logic [WIDTH-1:0]        branch_pc,
    input  logic [WIDTH-1:0]        branch_imm,
    input  logic [JUMP_INDEX_W-1:0] jump_index,
    output logic [WIDTH-1:0]        pc_plus4,
    output logic [WIDTH-1:0]        branch_target,
    output logic [WIDTH-1:0]        jump_target
);

    assign pc_plus4      = pc + WIDTH'(4);
    // Word offset scaled to bytes; wraps silently modulo 2^WIDTH.
    assign branch_target = branch_pc + (branch_imm << 2);
    // Jump stays inside the 256 MB region of the sequential successor.
    assign jump_target   = {pc_plus4[WIDTH-1:WIDTH-4], jump_index, 2'b00};

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-address sequencer with stall, branch/jump redirect, flush and halt control.
// Optional redirect alignment checking is enabled by defining PC_ALIGN_CHECK_EN.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int unsigned WIDTH    = ADDR_W
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    stall,
    input  logic                    branch_en,
    input  logic [WIDTH-1:0]        branch_pc,
    input  logic [WIDTH-1:0]        branch_imm,
    input  logic                    jump_en,
    input  logic [JUMP_INDEX_W-1:0] jump_index,
    input  logic                    halt_req,
    input  logic                    resume,
    input  logic                    fetch_ready,
    output logic                    fetch_valid,
    output logic [WIDTH-1:0]        pc_out,
    output logic [WIDTH-1:0]        pc_plus4,
    output logic                    flush,
    output logic                    halted,
    output logic                    misalign
);

    state_t           state;
    logic             redirect;
    logic [WIDTH-1:0] branch_target;
    logic [WIDTH-1:0] jump_target;
    logic [WIDTH-1:0] target_raw;
    logic [WIDTH-1:0] target;

    pc_target_calc #(.WIDTH(WIDTH)) u_target_calc (
        .pc            (pc_out),
        .branch_pc     (branch_pc),
        .branch_imm    (branch_imm),
        .jump_index    (jump_index),
        .pc_plus4      (pc_plus4),
        .branch_target (branch_target),
        .jump_target   (jump_target)
    );

    // Jump wins over branch when both resolve in the same cycle.
    assign redirect   = jump_en | branch_en;
    assign target_raw = jump_en ? jump_target : branch_target;

`ifdef PC_ALIGN_CHECK_EN
    assign target = target_raw;
`else
    assign target = target_raw & ~WIDTH'(3);
    assign misalign = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= BOOT;
            pc_out      <= WIDTH'(RESET_PC);
            fetch_valid <= 1'b0;
            flush       <= 1'b0;
            halted      <= 1'b0;
`ifdef PC_ALIGN_CHECK_EN
            misalign    <= 1'b0;
`endif
        end else begin
            flush <= 1'b0;
            case (state)
                BOOT: begin
                    state       <= RUN;
                    fetch_valid <= 1'b1;
                end
                RUN, FLUSH: begin
                    if (redirect) begin
`ifdef PC_ALIGN_CHECK_EN
                        // Misaligned target: keep the old PC and park in HALT.
                        if (target[1:0] != 2'b00) begin
                            misalign    <= 1'b1;
                            state       <= HALT;
                            halted      <= 1'b1;
                            fetch_valid <= 1'b0;
                        end else
`endif
                        begin
                            pc_out      <= target;
                            flush       <= 1'b1;
                            fetch_valid <= 1'b0;
                            if (state == RUN && halt_req) begin
                                state  <= HALT;
                                halted <= 1'b1;
                            end else begin
                                state  <= FLUSH;
                            end
                        end
                    end else if (state == RUN) begin
                        if (fetch_valid && fetch_ready && !stall) begin
                            pc_out <= pc_plus4;
                        end
                        if (halt_req) begin
                            state       <= HALT;
                            halted      <= 1'b1;
                            fetch_valid <= 1'b0;
                        end
                    end else begin
                        state       <= RUN;
                        fetch_valid <= 1'b1;
                    end
                end
                HALT: begin
                    if (!halt_req && resume) begin
                        state       <= RUN;
                        halted      <= 1'b0;
                        fetch_valid <= 1'b1;
`ifdef PC_ALIGN_CHECK_EN
                        misalign    <= 1'b0;
`endif
                    end
                end
                default: begin
                    state       <= BOOT;
                    fetch_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: directed stimulus queues expected snapshots, a monitor checks them.
module tb_pc_sequencer;
    import pc_seq_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        branch_en = 1'b0;
    logic [31:0] branch_pc = 32'h0;
    logic [31:0] branch_imm = 32'h0;
    logic        jump_en = 1'b0;
    logic [25:0] jump_index = 26'h0;
    logic        halt_req = 1'b0;
    logic        resume = 1'b0;
    logic        fetch_ready = 1'b0;
    logic        fetch_valid;
    logic [31:0] pc_out;
    logic [31:0] pc_plus4;
    logic        flush;
    logic        halted;
    logic        misalign;

    typedef struct {
        string       name;
        logic [31:0] pc;
        logic        fv;
        logic        fl;
        logic        h;
        logic        m;
    } exp_t;

    exp_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;

    pc_sequencer #(.RESET_PC(32'h0000_0000), .WIDTH(32)) dut (
        .clk         (clk),
        .reset       (reset),
        .stall       (stall),
        .branch_en   (branch_en),
        .branch_pc   (branch_pc),
        .branch_imm  (branch_imm),
        .jump_en     (jump_en),
        .jump_index  (jump_index),
        .halt_req    (halt_req),
        .resume      (resume),
        .fetch_ready (fetch_ready),
        .fetch_valid (fetch_valid),
        .pc_out      (pc_out),
        .pc_plus4    (pc_plus4),
        .flush       (flush),
        .halted      (halted),
        .misalign    (misalign)
    );

    always #5 clk = ~clk;

    task automatic push_exp(input string name, input logic [31:0] pc,
                            input logic fv, input logic fl, input logic h, input logic m);
        exp_t e;
        e.name = name;
        e.pc   = pc;
        e.fv   = fv;
        e.fl   = fl;
        e.h    = h;
        e.m    = m;
        exp_q.push_back(e);
    endtask

    // Expect the given outputs after the next rising edge, then move to the following negedge.
    task automatic tick(input string name, input logic [31:0] pc,
                        input logic fv, input logic fl, input logic h, input logic m);
        push_exp(name, pc, fv, fl, h, m);
        @(negedge clk);
    endtask

    // Monitor: samples shortly after each clock edge or reset assertion.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk or posedge reset);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                vectors++;
                if (pc_out !== e.pc || pc_plus4 !== (e.pc + 32'd4) || fetch_valid !== e.fv ||
                    flush !== e.fl || halted !== e.h || misalign !== e.m) begin
                    miscompares++;
                    $display("FAIL %s: got pc=%h pc4=%h fv=%b fl=%b h=%b m=%b, expected pc=%h pc4=%h fv=%b fl=%b h=%b m=%b",
                             e.name, pc_out, pc_plus4, fetch_valid, flush, halted, misalign,
                             e.pc, e.pc + 32'd4, e.fv, e.fl, e.h, e.m);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, expected finish before 100000");
        $fatal(1, "watchdog expired");
    end

    initial begin
        @(negedge clk);
        tick("reset_hold", 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Release reset; BOOT lasts one cycle then sequential fetch.
        reset = 1'b0;
        fetch_ready = 1'b1;
        tick("boot_exit", 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
        tick("seq_4",  32'h4,  1'b1, 1'b0, 1'b0, 1'b0);
        tick("seq_8",  32'h8,  1'b1, 1'b0, 1'b0, 1'b0);
        tick("seq_c",  32'hC,  1'b1, 1'b0, 1'b0, 1'b0);
        tick("seq_10", 32'h10, 1'b1, 1'b0, 1'b0, 1'b0);

        // Backward branch: 0x14 + (-2 << 2) = 0x0C.
        fetch_ready = 1'b0;
        branch_en = 1'b1; branch_pc = 32'h14; branch_imm = 32'hFFFF_FFFE;
        tick("branch_back", 32'hC, 1'b0, 1'b1, 1'b0, 1'b0);
        branch_en = 1'b0;
        tick("branch_back_done", 32'hC, 1'b1, 1'b0, 1'b0, 1'b0);

        branch_en = 1'b1; branch_pc = 32'h4000_0000; branch_imm = 32'h0;
        tick("branch_far", 32'h4000_0000, 1'b0, 1'b1, 1'b0, 1'b0);
        branch_en = 1'b0;
        tick("branch_far_done", 32'h4000_0000, 1'b1, 1'b0, 1'b0, 1'b0);

        // Jump and branch together: jump wins.
        jump_en = 1'b1; jump_index = 26'h10;
        branch_en = 1'b1; branch_pc = 32'h100; branch_imm = 32'h4;
        tick("jump_priority", 32'h4000_0040, 1'b0, 1'b1, 1'b0, 1'b0);
        jump_en = 1'b0; branch_en = 1'b0;
        tick("jump_done", 32'h4000_0040, 1'b1, 1'b0, 1'b0, 1'b0);

        // Stall with memory not ready: PC held, request stays valid.
        stall = 1'b1;
        for (int i = 0; i < 4; i++) tick("stall_hold", 32'h4000_0040, 1'b1, 1'b0, 1'b0, 1'b0);
        fetch_ready = 1'b1;
        tick("stall_ready_hold", 32'h4000_0040, 1'b1, 1'b0, 1'b0, 1'b0);
        jump_en = 1'b1; jump_index = 26'h20;
        tick("stall_jump", 32'h4000_0080, 1'b0, 1'b1, 1'b0, 1'b0);
        jump_en = 1'b0;
        tick("stall_jump_done", 32'h4000_0080, 1'b1, 1'b0, 1'b0, 1'b0);
        stall = 1'b0;
        tick("unstall_adv", 32'h4000_0084, 1'b1, 1'b0, 1'b0, 1'b0);

        // Redirect while already in FLUSH re-flushes.
        branch_en = 1'b1; branch_pc = 32'h200; branch_imm = 32'h1;
        fetch_ready = 1'b0;
        tick("branch_204", 32'h204, 1'b0, 1'b1, 1'b0, 1'b0);
        branch_pc = 32'h300; branch_imm = 32'h0;
        tick("flush_redirect", 32'h300, 1'b0, 1'b1, 1'b0, 1'b0);
        branch_en = 1'b0;
        tick("flush_redirect_done", 32'h300, 1'b1, 1'b0, 1'b0, 1'b0);

        // Halt completes the in-flight handshake first.
        halt_req = 1'b1; fetch_ready = 1'b1;
        tick("halt_enter", 32'h304, 1'b0, 1'b0, 1'b1, 1'b0);
        halt_req = 1'b0;
        tick("halt_stay", 32'h304, 1'b0, 1'b0, 1'b1, 1'b0);
        jump_en = 1'b1; jump_index = 26'h5;
        tick("halt_ignore_jump", 32'h304, 1'b0, 1'b0, 1'b1, 1'b0);
        jump_en = 1'b0;
        halt_req = 1'b1; resume = 1'b1;
        tick("halt_over_resume", 32'h304, 1'b0, 1'b0, 1'b1, 1'b0);
        halt_req = 1'b0; fetch_ready = 1'b0;
        tick("resume", 32'h304, 1'b1, 1'b0, 1'b0, 1'b0);
        resume = 1'b0;
        tick("resume_hold", 32'h304, 1'b1, 1'b0, 1'b0, 1'b0);

        // Halt together with a redirect: target loads, flush pulses, HALT.
        halt_req = 1'b1; branch_en = 1'b1; branch_pc = 32'h400; branch_imm = 32'h0;
        tick("halt_branch", 32'h400, 1'b0, 1'b1, 1'b1, 1'b0);
        halt_req = 1'b0; branch_en = 1'b0;
        tick("halt_branch_stay", 32'h400, 1'b0, 1'b0, 1'b1, 1'b0);
        resume = 1'b1;
        tick("halt_branch_resume", 32'h400, 1'b1, 1'b0, 1'b0, 1'b0);
        resume = 1'b0;

        // Misaligned redirect target 0x102.
        branch_en = 1'b1; branch_pc = 32'h102; branch_imm = 32'h0;
`ifdef PC_ALIGN_CHECK_EN
        tick("misalign_halt", 32'h400, 1'b0, 1'b0, 1'b1, 1'b1);
        branch_en = 1'b0; resume = 1'b1;
        tick("misalign_resume", 32'h400, 1'b1, 1'b0, 1'b0, 1'b0);
`else
        tick("misalign_forced", 32'h100, 1'b0, 1'b1, 1'b0, 1'b0);
        branch_en = 1'b0; resume = 1'b1;
        tick("misalign_resume", 32'h100, 1'b1, 1'b0, 1'b0, 1'b0);
`endif
        resume = 1'b0;

        // Asynchronous reset in the middle of FLUSH.
        branch_en = 1'b1; branch_pc = 32'h500; branch_imm = 32'h0;
        tick("flush_pre_reset", 32'h500, 1'b0, 1'b1, 1'b0, 1'b0);
        branch_en = 1'b0;
        push_exp("reset_async", 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1 reset = 1'b1;
        @(negedge clk);
        branch_en = 1'b1; jump_en = 1'b1; halt_req = 1'b1;
        tick("reset_held", 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        branch_en = 1'b0; jump_en = 1'b0; halt_req = 1'b0; fetch_ready = 1'b1;
        tick("reboot_exit", 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
        tick("reboot_seq_4", 32'h4, 1'b1, 1'b0, 1'b0, 1'b0);

        repeat (2) @(negedge clk);
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: got %0d pending entries, expected 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
